// File: rtl/fractal_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module      : fractal_vga_scanout
// Description : VGA scan-out for a signed 8-bit iteration-count framebuffer.
//               Generates sync timing, issues one read per active pixel to a
//               two-cycle-latency RAM, realigns sync with the returned data
//               and maps each count to RGB. The optional macro
//               FRACTAL_SCANOUT_PALETTE_EN selects a false-colour map instead
//               of greyscale.
// Revision    : 1.0 - initial release
// ============================================================================
module fractal_vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19
) (
  input  logic              clock,
  input  logic              reset,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic signed [7:0] rd_data,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_start
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_HW      = $clog2(c_H_TOTAL);
  localparam int c_VW      = $clog2(c_V_TOTAL);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  // S0 counters
  logic [c_HW-1:0] r_hcnt;
  logic [c_VW-1:0] r_vcnt;

  // S1..S3 sync/enable delay line (S1 de is rd_en itself)
  logic r_s1_hs, r_s1_vs;
  logic r_s2_de, r_s2_hs, r_s2_vs;
  logic r_s3_de, r_s3_hs, r_s3_vs;

  logic w_h_last, w_v_last;
  logic w_active, w_hs_n, w_vs_n, w_fs;
  logic [7:0] w_r, w_g, w_b;

  assign w_h_last = (r_hcnt == c_HW'(c_H_TOTAL - 1));
  assign w_v_last = (r_vcnt == c_VW'(c_V_TOTAL - 1));
  assign w_active = (r_hcnt < c_HW'(H_ACTIVE)) && (r_vcnt < c_VW'(V_ACTIVE));
  assign w_hs_n   = !((r_hcnt >= c_HW'(H_ACTIVE + H_FP)) &&
                      (r_hcnt <  c_HW'(H_ACTIVE + H_FP + H_SYNC)));
  assign w_vs_n   = !((r_vcnt >= c_VW'(V_ACTIVE + V_FP)) &&
                      (r_vcnt <  c_VW'(V_ACTIVE + V_FP + V_SYNC)));
  assign w_fs     = (r_hcnt == '0) && (r_vcnt == '0);

  // Free-running horizontal/vertical position counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_last) begin
      r_hcnt <= '0;
      r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  // S1: RAM request; address is a running pixel counter that holds through
  // blanking and wraps right after the last pixel of the frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      frame_start <= 1'b0;
      r_s1_hs     <= 1'b1;
      r_s1_vs     <= 1'b1;
    end else begin
      rd_en       <= w_active;
      frame_start <= w_fs;
      r_s1_hs     <= w_hs_n;
      r_s1_vs     <= w_vs_n;
      if (w_fs) begin
        rd_addr <= '0;
      end else if (rd_en) begin
        rd_addr <= (rd_addr == c_LAST_ADDR) ? '0 : rd_addr + 1'b1;
      end
    end
  end

  // S2/S3: cover the two-cycle RAM read latency
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2_de <= 1'b0;
      r_s2_hs <= 1'b1;
      r_s2_vs <= 1'b1;
      r_s3_de <= 1'b0;
      r_s3_hs <= 1'b1;
      r_s3_vs <= 1'b1;
    end else begin
      r_s2_de <= rd_en;
      r_s2_hs <= r_s1_hs;
      r_s2_vs <= r_s1_vs;
      r_s3_de <= r_s2_de;
      r_s3_hs <= r_s2_hs;
      r_s3_vs <= r_s2_vs;
    end
  end

`ifdef FRACTAL_SCANOUT_PALETTE_EN
  // Bit 6 does not feed the false-colour map
  logic w_unused;
  assign w_unused = rd_data[6];

  // False-colour map; negative counts (in-set) and blanking are black
  always_comb begin
    w_r = 8'h00;
    w_g = 8'h00;
    w_b = 8'h00;
    if (r_s3_de && !rd_data[7]) begin
      w_r = {rd_data[3:0], 4'h0};
      w_g = {rd_data[5:2], 4'h0};
      w_b = {~rd_data[3:0], 4'h0};
    end
  end
`else
  // Greyscale map; negative counts (in-set) and blanking are black
  always_comb begin
    w_r = 8'h00;
    w_g = 8'h00;
    w_b = 8'h00;
    if (r_s3_de && !rd_data[7]) begin
      w_r = {rd_data[6:0], 1'b0};
      w_g = {rd_data[6:0], 1'b0};
      w_b = {rd_data[6:0], 1'b0};
    end
  end
`endif

  // S4: registered outputs to the DAC/HDMI bridge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_de <= 1'b0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= 8'h00;
      vga_g  <= 8'h00;
      vga_b  <= 8'h00;
    end else begin
      vga_de <= r_s3_de;
      vga_hs <= r_s3_hs;
      vga_vs <= r_s3_vs;
      vga_r  <= w_r;
      vga_g  <= w_g;
      vga_b  <= w_b;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fractal_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_fractal_vga_scanout
// Description : Scoreboard bench for fractal_vga_scanout with small timing
//               (H 8/1/2/1, V 4/1/1/1) and a two-cycle registered RAM model.
//               Define FRACTAL_SCANOUT_PALETTE_EN to expect the false-colour map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fractal_vga_scanout;

  localparam int HA = 8, HFP = 1, HS = 2, HBP = 1;
  localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int NPIX = HA * VA;
  localparam int FRAME = HT * VT;
  localparam int AW = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic signed [7:0] rd_data = '0;
  logic              vga_hs, vga_vs, vga_de, frame_start;
  logic [7:0]        vga_r, vga_g, vga_b;

  logic signed [7:0] mem [64];
  logic signed [7:0] p1 = '0;
  logic [23:0]       sb[$];
  int                k = 0;
  int                compared = 0;
  int                mismatched = 0;
  bit                mon_en = 1'b0;

  fractal_vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .ADDR_W(AW)
  ) dut (
    .clock(clk), .reset(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Two-cycle registered-read framebuffer
  always @(posedge clk) begin
    if (rd_en) p1 <= mem[rd_addr];
    rd_data <= p1;
  end

  // Edges elapsed since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  // Reference model: position index j = clock edges since release
  function automatic int hpos(int j); return j % HT; endfunction
  function automatic int vpos(int j); return (j / HT) % VT; endfunction
  function automatic bit is_act(int j); return hpos(j) < HA && vpos(j) < VA; endfunction
  function automatic bit hs_n(int j);
    return !(hpos(j) >= HA + HFP && hpos(j) < HA + HFP + HS);
  endfunction
  function automatic bit vs_n(int j);
    return !(vpos(j) >= VA + VFP && vpos(j) < VA + VFP + VS);
  endfunction
  function automatic bit is_fs(int j); return hpos(j) == 0 && vpos(j) == 0; endfunction
  // Address on the bus: current pixel if active, else the next pixel to read
  function automatic int addr_exp(int j);
    if (vpos(j) >= VA) return 0;
    if (hpos(j) < HA) return vpos(j) * HA + hpos(j);
    return ((vpos(j) + 1) * HA) % NPIX;
  endfunction
  function automatic logic [23:0] colour(int d);
    int r, g, b;
    if (d < 0) return 24'h0;
`ifdef FRACTAL_SCANOUT_PALETTE_EN
    r = (d % 16) * 16;
    g = ((d / 4) % 16) * 16;
    b = (15 - d % 16) * 16;
`else
    r = d * 2; g = d * 2; b = d * 2;
`endif
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s k=%0d t=%0t: got %0h expected %0h", name, k, $time, got, exp);
    end
  endtask

  task automatic push_frames(input int n);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < NPIX; i++)
        sb.push_back(colour(int'(mem[i])));
  endtask

  // Monitor: timing against the model, colour against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      bit ede, ehs, evs;
      logic [23:0] e;
      check("rd_en", {31'b0, rd_en}, (k >= 1) ? {31'b0, is_act(k - 1)} : 32'd0);
      check("frame_start", {31'b0, frame_start}, (k >= 1) ? {31'b0, is_fs(k - 1)} : 32'd0);
      check("rd_addr", {26'b0, rd_addr}, (k >= 1) ? addr_exp(k - 1) : 0);
      if (k >= 4) begin
        ede = is_act(k - 4); ehs = hs_n(k - 4); evs = vs_n(k - 4);
      end else begin
        ede = 1'b0; ehs = 1'b1; evs = 1'b1;
      end
      check("vga_de", {31'b0, vga_de}, {31'b0, ede});
      check("vga_hs", {31'b0, vga_hs}, {31'b0, ehs});
      check("vga_vs", {31'b0, vga_vs}, {31'b0, evs});
      if (vga_de && ede) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL scoreboard_empty k=%0d: pixel emitted with no expected colour", k);
        end else begin
          e = sb.pop_front();
          compared--;
          check("pixel_rgb", {8'b0, vga_r, vga_g, vga_b}, {8'b0, e});
        end
      end else if (!vga_de) begin
        check("blank_rgb", {8'b0, vga_r, vga_g, vga_b}, 32'd0);
      end
    end
  end

  initial begin
    // Phase 1: ramp image mem[i]=i
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    push_frames(3);
    @(negedge clk);
    rst = 1'b0;
    // Run into frame 3, line 1, stop where hcnt = 3
    repeat (2 * FRAME + HT + 3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rd_en", {31'b0, rd_en}, 32'd0);
    check("async_rd_addr", {26'b0, rd_addr}, 32'd0);
    check("async_de", {31'b0, vga_de}, 32'd0);
    check("async_hs", {31'b0, vga_hs}, 32'd1);
    check("async_vs", {31'b0, vga_vs}, 32'd1);
    check("async_fs", {31'b0, frame_start}, 32'd0);
    check("async_rgb", {8'b0, vga_r, vga_g, vga_b}, 32'd0);
    // Phase 2: random image with in-set marker and bright pixel
    sb.delete();
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[5] = -8'sd1;
`ifdef FRACTAL_SCANOUT_PALETTE_EN
    mem[6] = 8'sd6;
`else
    mem[6] = 8'sd127;
`endif
    push_frames(3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * FRAME + 20) @(posedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
